uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Asynchronous serial receiver, 8N1 (1 start, 8 data LSB-first, 1 stop, no parity).
//   Oversamples rx_serial with the system clock and delivers each byte with a one-cycle strobe.
//   Sits behind the board UART pin; feeds command/parser logic in the clk domain.
// PARAMETERS
//   CLKS_PER_BIT  10417  clk cycles per bit (100 MHz / 9600 baud); legal range >= 4.
// PORTS
//   clk         in   1  system clock; all logic on rising edge.
//   rst_n       in   1  asynchronous, active-low reset.
//   rx_serial   in   1  serial line, idle high, asynchronous to clk.
//   rx_byte     out  8  last received byte; stable between rx_done pulses.
//   rx_done     out  1  one-cycle pulse, byte valid on rx_byte.
//   rx_frame_err out 1  only with UART_RX_FRAME_ERR_EN; see CONFIGURATION.
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, rx_byte=8'h00, rx_done=0,
//     rx_frame_err=0, bit/clock counters=0, synchronizer flops=1 (idle line).
//   - rx_serial passes through a 2-flop synchronizer; FSM sees only rx_sync.
//   - States: IDLE -> START -> DATA -> STOP -> DONE -> IDLE.
//   - IDLE: wait for rx_sync==0; clear clock counter; go START.
//   - START: count to (CLKS_PER_BIT-1)/2 (bit centre); if rx_sync still 0 go DATA and
//     clear counter, else false start -> IDLE (no rx_done).
//   - DATA: every CLKS_PER_BIT cycles sample rx_sync into shift reg bit[idx], idx 0..7
//     (LSB first); after idx 7 go STOP.
//   - STOP: after CLKS_PER_BIT cycles sample stop bit at centre, then wait a further
//     CLKS_PER_BIT/2 cycles (end of stop bit), go DONE.
//   - DONE: one cycle: rx_byte <= shift reg, rx_done=1; next cycle IDLE.
//   - Latency: rx_done rises ~(9.5*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3) cycles after the start
//     edge, i.e. after the stop bit has fully elapsed on the line.
//   - Back-to-back frames: a start edge arriving the cycle after DONE is accepted.
//   - Line held low (break): frame completes as 8'h00; stop sampled low (see CONFIGURATION);
//     IDLE then restarts on the still-low line.
//   - Changes on rx_serial during DATA between sample points are ignored.
//   - rst_n asserted mid-frame: immediate abort to IDLE, partial byte discarded, no rx_done.
//   - Counter width $clog2(CLKS_PER_BIT); bit index 3 bits.
// CONFIGURATION
//   UART_RX_FRAME_ERR_EN defined: port rx_frame_err present; if the stop bit is sampled 0,
//     DONE pulses rx_frame_err instead of rx_done and rx_byte is NOT updated.
//   Undefined: no rx_frame_err port; stop value ignored, rx_done and rx_byte update always.
// STRUCTURE
//   Package uart_pkg: typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,STOP,DONE};
//     localparam DATA_BITS=8.
//   Sub-module sync_2ff (1-bit, reset value parameter) for rx_serial synchronization.
// TESTING (CLKS_PER_BIT=10, 10 ns clk, 100 ns per bit)
//   1 Reset: rst_n=0 20 ns -> rx_byte=8'h00, rx_done=0; idle line high -> no rx_done.
//   2 Send 8'h41 -> exactly one rx_done pulse, after stop bit ends, rx_byte=8'h41.
//   3 100 random bytes, 50 ns gap after each rx_done -> every rx_byte equals sent byte, 0 errors.
//   4 Low glitch of 30 ns on idle line -> no rx_done, FSM back in IDLE; next 8'hA5 received OK.
//   5 rst_n pulsed mid-data of 8'h3C -> no rx_done; following 8'hC3 received correctly.
//   6 Frame 8'h55 with stop bit 0 -> with macro: rx_frame_err pulse, rx_byte unchanged;
//     without macro: rx_done pulse, rx_byte=8'h55.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the 8N1 UART receiver.
//   - uart_rx_state_t : receiver FSM states
//   - DATA_BITS       : payload bits per frame
// Optional feature macro used by the files that import this package:
//   UART_RX_FRAME_ERR_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
//   Byte-delivery interface between the UART receiver and its consumer.
//   Signals:
//     rx_byte      [7:0] last received byte, stable between strobes
//     rx_done            one-cycle strobe, rx_byte valid
//     rx_frame_err       one-cycle strobe, stop bit sampled low
//                        (present only with UART_RX_FRAME_ERR_EN)
//   Modports:
//     master : receiver side (drives the signals)
//     slave  : consumer side (observes the signals)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_done;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 rx_frame_err;
`endif

`ifdef UART_RX_FRAME_ERR_EN
    modport master (output rx_byte, output rx_done, output rx_frame_err);
    modport slave  (input  rx_byte, input  rx_done, input  rx_frame_err);
`else
    modport master (output rx_byte, output rx_done);
    modport slave  (input  rx_byte, input  rx_done);
`endif

endinterface : uart_receiver_if

// File: rtl/uart_receiver_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input bit.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset (flops load RESET_VAL)
//     d      in  asynchronous input
//     q      out synchronized output, two clk cycles of latency
//   Parameters:
//     RESET_VAL  value both flops take in reset (idle level of the input)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // The first flop may go metastable; only the second flop is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments here, so both flops sample the
            // pre-edge values and the chain really is two stages deep.
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : sync_2ff

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 asynchronous serial receiver (1 start, 8 data LSB first, 1 stop).
//   rx_serial is synchronized, the start edge is qualified at the centre of
//   the start bit, and each data bit is then sampled at its centre. The byte
//   is delivered once the stop bit has fully elapsed on the line.
//   Ports:
//     clk        in  system clock, rising edge
//     rst_n      in  asynchronous active-low reset
//     rx_serial  in  serial line, idle high, asynchronous to clk
//     rx_if      uart_receiver_if.master: rx_byte, rx_done (and rx_frame_err)
//   Parameters:
//     CLKS_PER_BIT  clk cycles per bit, >= 4
//   Optional feature:
//     UART_RX_FRAME_ERR_EN  when defined, a stop bit sampled low pulses
//                           rx_frame_err instead of rx_done and rx_byte holds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_serial,
    uart_receiver_if.master rx_if
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_STOP_TAIL = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_IDX      = 3'(DATA_BITS - 1);

    logic rx_sync;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rx_sync)
    );

    uart_rx_state_t       state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [2:0]           bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 stop_seen_q, stop_seen_d;
    logic [DATA_BITS-1:0] rx_byte_q,   rx_byte_d;
    logic                 rx_done_q,   rx_done_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 stop_bit_q,  stop_bit_d;
    logic                 frame_err_q, frame_err_d;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_seen_d = stop_seen_q;
        rx_byte_d   = rx_byte_q;
        rx_done_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        stop_bit_d  = stop_bit_q;
        frame_err_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d       = '0;
                bit_idx_d   = '0;
                stop_seen_d = 1'b0;
                if (!rx_sync) state_d = START;
            end

            // Re-check the line at mid start bit to reject short glitches.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counter is now phase-aligned to bit centres.
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_sync;
                    if (bit_idx_q == LAST_IDX) state_d   = STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Two phases: reach the stop-bit centre, then run out the second
            // half of the stop bit so delivery follows the end of the frame.
            STOP: begin
                if (!stop_seen_q) begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_d       = '0;
                        stop_seen_d = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        stop_bit_d  = rx_sync;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == CNT_STOP_TAIL) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef UART_RX_FRAME_ERR_EN
                    if (!stop_bit_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        rx_done_d = 1'b1;
                        rx_byte_d = shift_q;
                    end
`else
                    rx_done_d = 1'b1;
                    rx_byte_d = shift_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Strobes are registered on entry, so they are high for exactly
            // this one cycle with rx_byte already updated.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            stop_seen_q <= 1'b0;
            rx_byte_q   <= '0;
            rx_done_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bit_q  <= 1'b1;
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            stop_seen_q <= stop_seen_d;
            rx_byte_q   <= rx_byte_d;
            rx_done_q   <= rx_done_d;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bit_q  <= stop_bit_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign rx_if.rx_byte      = rx_byte_q;
    assign rx_if.rx_done      = rx_done_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign rx_if.rx_frame_err = frame_err_q;
`endif

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver at CLKS_PER_BIT=10, 10 ns clock.
//   Expected bytes are queued when a frame is driven and popped on rx_done.
//   Honors UART_RX_FRAME_ERR_EN for the stop-bit-low frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB    = 10;
    localparam int BIT_NS = 100;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_serial;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;

    int         n_pass   = 0;
    int         n_fail   = 0;
    int         n_total  = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    time        last_done_t = 0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        logic [7:0] exp_b;
        if (rst_n) begin
            if (rx_if.rx_done) begin
                done_cnt++;
                last_done_t = $time;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("rx_byte", 32'(rx_if.rx_byte), 32'(exp_b));
                end
            end
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_if.rx_frame_err) err_cnt++;
`endif
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val, output time t_start);
        @(negedge clk);
        t_start   = $time;
        rx_serial = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            #BIT_NS;
        end
        rx_serial = stop_val;
        #BIT_NS;
        rx_serial = 1'b1;
    endtask

    task automatic wait_done(input int prev, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > prev) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin : stim
        time        t0;
        bit         got;
        int         prev;
        logic [7:0] b;

        // 1: reset
        rx_serial = 1'b1;
        rst_n     = 1'b0;
        #10;
        check("reset_rx_byte", 32'(rx_if.rx_byte), 32'h00);
        check("reset_rx_done", 32'(rx_if.rx_done), 32'd0);
        #10;
        rst_n = 1'b1;
        #500;
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // 2: single byte, latency and exactly one pulse
        prev = done_cnt;
        sb.push_back(8'h41);
        send_byte(8'h41, 1'b1, t0);
        wait_done(prev, 300, got);
        check("done_41_seen", 32'(got), 32'd1);
        check("latency_after_stop", 32'((last_done_t - t0) >= 1000), 32'd1);
        check("latency_bound", 32'((last_done_t - t0) <= 1100), 32'd1);
        repeat (200) @(negedge clk);
        check("done_41_once", 32'(done_cnt), 32'(prev + 1));
        check("hold_41", 32'(rx_if.rx_byte), 32'h41);

        // 3: random bytes, 50 ns gap after each rx_done
        for (int k = 0; k < 100; k++) begin
            b    = 8'($urandom_range(0, 255));
            prev = done_cnt;
            sb.push_back(b);
            send_byte(b, 1'b1, t0);
            wait_done(prev, 300, got);
            check("rand_done_seen", 32'(got), 32'd1);
            #50;
        end

        // 4: 30 ns glitch on idle line
        @(negedge clk);
        prev      = done_cnt;
        rx_serial = 1'b0;
        #30;
        rx_serial = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_done", 32'(done_cnt), 32'(prev));
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, t0);
        wait_done(prev, 300, got);
        check("done_a5_seen", 32'(got), 32'd1);

        // 5: reset in the middle of 8'h3C
        @(negedge clk);
        prev      = done_cnt;
        rx_serial = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            rx_serial = i[1];   // bits of 8'h3C: 0,0,1,1
            #BIT_NS;
        end
        rx_serial = 1'b1;
        #50;
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        #1500;
        check("abort_no_done", 32'(done_cnt), 32'(prev));
        check("abort_rx_byte", 32'(rx_if.rx_byte), 32'h00);
        sb.push_back(8'hC3);
        send_byte(8'hC3, 1'b1, t0);
        wait_done(prev, 300, got);
        check("done_c3_seen", 32'(got), 32'd1);
        #50;

        // 6: stop bit low
        prev = done_cnt;
`ifdef UART_RX_FRAME_ERR_EN
        begin
            int prev_err;
            prev_err = err_cnt;
            send_byte(8'h55, 1'b0, t0);
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                #1;
                if (err_cnt > prev_err) begin
                    got = 1'b1;
                    break;
                end
            end
            check("frame_err_seen", 32'(got), 32'd1);
            repeat (50) @(negedge clk);
            check("frame_err_once", 32'(err_cnt), 32'(prev_err + 1));
            check("frame_err_no_done", 32'(done_cnt), 32'(prev));
            check("frame_err_hold", 32'(rx_if.rx_byte), 32'hC3);
        end
`else
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b0, t0);
        wait_done(prev, 300, got);
        check("done_55_seen", 32'(got), 32'd1);
        repeat (50) @(negedge clk);
        check("hold_55", 32'(rx_if.rx_byte), 32'h55);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_receiver
